// File: rtl/jpeg_ctrl_pkg.sv
// jpeg_ctrl_pkg
// Shared types and constants for the JPEG decoder control blocks.
//   ch_e        : channel tag carried alongside each 8x8 block (Y/Cb/Cr)
//   subsamp_e   : chroma subsampling mode of the current frame
//   seq_state_e : MCU channel sequencer states
//   chan_of()   : block position inside an MCU -> channel tag
package jpeg_ctrl_pkg;

   typedef enum logic [1:0] {
      CH_Y  = 2'd0,
      CH_CB = 2'd1,
      CH_CR = 2'd2
   } ch_e;

   typedef enum logic {
      SS_444 = 1'b0,
      SS_420 = 1'b1
   } subsamp_e;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } seq_state_e;

   localparam int BLK_PER_MCU_444 = 3;
   localparam int BLK_PER_MCU_420 = 6;

   // Wide enough for the largest MCU (6 blocks in 4:2:0).
   localparam int IDX_W = 3;

   // 4:2:0 carries four luma blocks before Cb and Cr; 4:4:4 is one of each.
   function automatic ch_e chan_of(input subsamp_e mode, input logic [IDX_W-1:0] idx);
      ch_e ch;
      ch = CH_Y;
      if (mode == SS_420) begin
         if (idx == 3'd4) begin
            ch = CH_CB;
         end else if (idx == 3'd5) begin
            ch = CH_CR;
         end
      end else begin
         if (idx == 3'd1) begin
            ch = CH_CB;
         end else if (idx == 3'd2) begin
            ch = CH_CR;
         end
      end
      return ch;
   endfunction

endpackage

// File: rtl/mcu_block_counter.sv
// mcu_block_counter
// Tracks the position of the next block inside the current MCU.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : return to the first block of an MCU
//   adv      : one block was accepted this cycle
//   mode     : subsampling mode of the frame (sets MCU length)
//   chan     : channel tag of the block at the current position
//   is_last  : current position is the final block of the MCU
module mcu_block_counter
   import jpeg_ctrl_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     clr,
   input  logic     adv,
   input  subsamp_e mode,
   output ch_e      chan,
   output logic     is_last
);

   localparam logic [IDX_W-1:0] LAST_444 = IDX_W'(BLK_PER_MCU_444 - 1);
   localparam logic [IDX_W-1:0] LAST_420 = IDX_W'(BLK_PER_MCU_420 - 1);

   logic [IDX_W-1:0] idx;

   assign is_last = (mode == SS_420) ? (idx == LAST_420) : (idx == LAST_444);
   assign chan    = chan_of(mode, idx);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (adv) begin
         idx <= is_last ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/mcu_channel_sequencer.sv
// mcu_channel_sequencer
// Feeds the supersample/channel buffer one 8x8 block at a time in MCU order,
// tags each block with its channel and limits the MCUs in flight.
// Optional watchdog: define MCU_SEQ_TIMEOUT_EN.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : frame start pulse (latches subsamp_mode, mcu_total)
//   subsamp_mode    : 0 = 4:4:4, 1 = 4:2:0
//   mcu_total       : MCUs in the frame
//   blk_valid       : upstream block available
//   blk_ready       : block accepted this cycle
//   ss_valid, ss_ch : supersample buffer valid_in / ch_in
//   buf_mcu_valid   : buffer emitted one MCU (returns a credit)
//   mcu_done_cnt    : MCUs confirmed this frame
//   busy            : not idle
//   frame_done      : one-cycle pulse at frame end
//   err_unexpected  : sticky, buf_mcu_valid with no credit outstanding
//   err_timeout     : sticky watchdog error (0 without the watchdog)
module mcu_channel_sequencer
   import jpeg_ctrl_pkg::*;
#(
   parameter int CH_W            = 2,
   parameter int MCU_CNT_W       = 16,
   parameter int MAX_OUTSTANDING = 2,
   parameter int TIMEOUT_CYCLES  = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 subsamp_mode,
   input  logic [MCU_CNT_W-1:0] mcu_total,
   input  logic                 blk_valid,
   output logic                 blk_ready,
   output logic                 ss_valid,
   output logic [CH_W-1:0]      ss_ch,
   input  logic                 buf_mcu_valid,
   output logic [MCU_CNT_W-1:0] mcu_done_cnt,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 err_unexpected,
   output logic                 err_timeout
);

   // MAX_OUTSTANDING is at most 7, so three bits always hold the credit count.
   localparam int                CRED_W   = 3;
   localparam logic [CRED_W-1:0] MAX_CRED = CRED_W'(MAX_OUTSTANDING);

   seq_state_e           state, next_state;
   subsamp_e             mode_q;
   logic [MCU_CNT_W-1:0] total_q;
   logic [MCU_CNT_W-1:0] mcu_issued;
   logic [CRED_W-1:0]    credits;
   logic                 start_acc, transfer, issue, last_mcu;
   logic                 buf_ok, buf_bad, wd_fire;
   ch_e                  chan;
   logic                 is_last;

   assign start_acc = start && (state == IDLE);
   assign blk_ready = (state == RUN) && (credits < MAX_CRED);
   assign transfer  = blk_valid && blk_ready;
   assign issue     = transfer && is_last;
   assign last_mcu  = issue && ((mcu_issued + MCU_CNT_W'(1)) == total_q);
   assign buf_ok    = buf_mcu_valid && (state != IDLE) && (credits != '0);
   assign buf_bad   = buf_mcu_valid && !buf_ok;
   assign busy      = (state != IDLE);

   mcu_block_counter u_blk_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     ((state == IDLE) || wd_fire),
      .adv     (transfer),
      .mode    (mode_q),
      .chan    (chan),
      .is_last (is_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (mcu_total == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_mcu) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (credits == '0) begin
               next_state = DONE;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      // A watchdog expiry abandons the frame without a frame_done pulse.
      if (wd_fire) begin
         next_state = IDLE;
      end
   end

   // A credit taken and returned in the same cycle leaves the count unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q         <= SS_444;
         total_q        <= '0;
         mcu_issued     <= '0;
         mcu_done_cnt   <= '0;
         credits        <= '0;
         ss_valid       <= 1'b0;
         ss_ch          <= '0;
         err_unexpected <= 1'b0;
      end else begin
         ss_valid <= transfer;
         if (transfer) begin
            ss_ch <= CH_W'(chan);
         end
         if (start_acc) begin
            mode_q         <= subsamp_e'(subsamp_mode);
            total_q        <= mcu_total;
            mcu_issued     <= '0;
            mcu_done_cnt   <= '0;
            err_unexpected <= 1'b0;
         end else begin
            if (issue) begin
               mcu_issued <= mcu_issued + MCU_CNT_W'(1);
            end
            if (buf_ok) begin
               mcu_done_cnt <= mcu_done_cnt + MCU_CNT_W'(1);
            end
            if (buf_bad) begin
               err_unexpected <= 1'b1;
            end
         end
         if (wd_fire) begin
            credits <= '0;
         end else if (issue && !buf_ok) begin
            credits <= credits + CRED_W'(1);
         end else if (!issue && buf_ok) begin
            credits <= credits - CRED_W'(1);
         end
      end
   end

`ifdef MCU_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            err_to_q;

   assign wd_fire     = (wd_cnt == WD_W'(TIMEOUT_CYCLES));
   assign err_timeout = err_to_q;

   // Counts only while MCUs are outstanding and the buffer stays silent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt   <= '0;
         err_to_q <= 1'b0;
      end else begin
         if ((state == IDLE) || buf_mcu_valid || wd_fire) begin
            wd_cnt <= '0;
         end else if (credits != '0) begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end
         if (start_acc) begin
            err_to_q <= 1'b0;
         end else if (wd_fire) begin
            err_to_q <= 1'b1;
         end
      end
   end
`else
   // No watchdog in this build; the limit is referenced only so the
   // parameter stays meaningful to callers that override it.
   assign wd_fire     = 1'b0;
   assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_mcu_channel_sequencer.sv
// tb_mcu_channel_sequencer
// Self-checking bench for mcu_channel_sequencer: a frame-level reference
// model (blocks sent, MCUs confirmed, frame phase) is compared against the
// DUT every cycle, plus hand-computed checks of the directed scenarios.
module tb_mcu_channel_sequencer;

   localparam int MAX_OUT    = 2;
   localparam int TB_TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        subsamp_mode = 1'b0;
   logic [15:0] mcu_total = '0;
   logic        blk_valid = 1'b0;
   logic        buf_mcu_valid = 1'b0;
   logic        blk_ready, ss_valid, busy, frame_done, err_unexpected, err_timeout;
   logic [1:0]  ss_ch;
   logic [15:0] mcu_done_cnt;

   int tests_run = 0;
   int fails     = 0;
   bit check_en  = 1'b0;

   mcu_channel_sequencer #(
      .CH_W            (2),
      .MCU_CNT_W       (16),
      .MAX_OUTSTANDING (MAX_OUT),
      .TIMEOUT_CYCLES  (TB_TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .subsamp_mode   (subsamp_mode),
      .mcu_total      (mcu_total),
      .blk_valid      (blk_valid),
      .blk_ready      (blk_ready),
      .ss_valid       (ss_valid),
      .ss_ch          (ss_ch),
      .buf_mcu_valid  (buf_mcu_valid),
      .mcu_done_cnt   (mcu_done_cnt),
      .busy           (busy),
      .frame_done     (frame_done),
      .err_unexpected (err_unexpected),
      .err_timeout    (err_timeout)
   );

   always #5 clk = ~clk;

   // Reference model: frame phase plus block/MCU bookkeeping.
   int m_total, m_sent, m_conf, e_ss_ch;
   bit m_mode420, m_active, m_done, m_err, e_ss_valid;
   int lut420[6] = '{0, 0, 0, 0, 1, 2};

   function automatic int bpm();
      return m_mode420 ? 6 : 3;
   endfunction

   function automatic int in_flight();
      return m_sent / bpm() - m_conf;
   endfunction

   function automatic bit e_busy();
      return m_active || m_done;
   endfunction

   function automatic bit e_ready();
      return m_active && (m_sent / bpm() < m_total) && (in_flight() < MAX_OUT);
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_total = 0; m_sent = 0; m_conf = 0; e_ss_ch = 0;
            m_mode420 = 0; m_active = 0; m_done = 0; m_err = 0; e_ss_valid = 0;
         end else begin
            bit xfer, ok, bad, drain_done, accept;
            int pos;
            xfer       = blk_valid && e_ready();
            ok         = buf_mcu_valid && (in_flight() > 0);
            bad        = buf_mcu_valid && !ok;
            drain_done = m_active && (m_sent / bpm() == m_total) && (in_flight() == 0);
            accept     = start && !e_busy();
            e_ss_valid = xfer;
            if (xfer) begin
               pos     = m_sent % bpm();
               e_ss_ch = m_mode420 ? lut420[pos] : pos;
               m_sent++;
            end
            if (ok) m_conf++;
            if (m_done) m_done = 0;
            if (drain_done) begin
               m_active = 0;
               m_done   = 1;
            end
            if (accept) begin
               m_mode420 = subsamp_mode;
               m_total   = int'(mcu_total);
               m_sent    = 0;
               m_conf    = 0;
               m_err     = 0;
               m_active  = (mcu_total != 0);
               m_done    = (mcu_total == 0);
            end else if (bad) begin
               m_err = 1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle compare against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (check_en) begin
            checkOutput("blk_ready", 32'(blk_ready), 32'(e_ready()));
            checkOutput("ss_valid", 32'(ss_valid), 32'(e_ss_valid));
            if (e_ss_valid) checkOutput("ss_ch", 32'(ss_ch), e_ss_ch);
            checkOutput("busy", 32'(busy), 32'(e_busy()));
            checkOutput("frame_done", 32'(frame_done), 32'(m_done));
            checkOutput("mcu_done_cnt", 32'(mcu_done_cnt), m_conf);
            checkOutput("err_unexpected", 32'(err_unexpected), 32'(m_err));
            checkOutput("err_timeout", 32'(err_timeout), 0);
         end
      end
   end

   // Event counters for the directed checks.
   int ss_cnt = 0;
   int fd_cnt = 0;
   bit collecting = 1'b0;
   int chq[$];

   initial begin
      forever begin
         @(negedge clk);
         if (ss_valid === 1'b1) begin
            ss_cnt++;
            if (collecting) chq.push_back(int'(ss_ch));
         end
         if (frame_done === 1'b1) fd_cnt++;
      end
   end

   task automatic applyStimulus(input logic s, input logic mode, input logic [15:0] tot,
                                input logic bv, input logic bmv);
      start         = s;
      subsamp_mode  = mode;
      mcu_total     = tot;
      blk_valid     = bv;
      buf_mcu_valid = bmv;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame_done(input int budget, input int fd_before);
      int n = 0;
      while (fd_cnt == fd_before && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("frame_done_seen", fd_cnt - fd_before, 1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish before 100000");
      $fatal(1, "[TB] simulation stopped");
   end

   int exp_seq[12] = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 2};

   initial begin
      int ss0, fd0;
      #1 rst = 1'b0;
      #1 check_en = 1'b1;
      #1;
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_ss_valid", 32'(ss_valid), 0);
      checkOutput("reset_done_cnt", 32'(mcu_done_cnt), 0);
      checkOutput("reset_err", 32'(err_unexpected), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);

      // 4:2:0, two MCUs, credits returned three cycles after each MCU.
      $display("[TB] scenario: 4:2:0 two MCUs");
      fd0 = fd_cnt;
      applyStimulus(1, 1, 16'd2, 0, 0);
      collecting = 1'b1;
      for (int c = 0; c < 21; c++) applyStimulus(0, 0, 0, 1, (c == 9) || (c == 15));
      collecting = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("seq_len", chq.size(), 12);
      for (int i = 0; i < 12; i++) begin
         if (i < chq.size()) checkOutput("seq_ch", chq[i], exp_seq[i]);
      end
      checkOutput("seq_frame_done_pulses", fd_cnt - fd0, 1);
      checkOutput("seq_done_cnt", 32'(mcu_done_cnt), 2);

      // 4:4:4, three MCUs, credits withheld to hit the in-flight limit.
      $display("[TB] scenario: 4:4:4 credit limit");
      applyStimulus(1, 0, 16'd3, 0, 0);
      ss0 = ss_cnt;
      for (int c = 0; c < 9; c++) applyStimulus(0, 0, 0, 1, 0);
      checkOutput("limit_transfers", ss_cnt - ss0, 6);
      checkOutput("limit_ready_low", 32'(blk_ready), 0);
      applyStimulus(0, 0, 0, 1, 1);
      for (int c = 0; c < 6; c++) applyStimulus(0, 0, 0, 1, 0);
      checkOutput("limit_after_release", ss_cnt - ss0, 9);
      fd0 = fd_cnt;
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      wait_frame_done(10, fd0);
      checkOutput("limit_done_cnt", 32'(mcu_done_cnt), 3);

      // Empty frame.
      $display("[TB] scenario: zero MCUs");
      ss0 = ss_cnt;
      fd0 = fd_cnt;
      applyStimulus(1, 0, 16'd0, 0, 0);
      checkOutput("zero_frame_done", 32'(frame_done), 1);
      checkOutput("zero_busy", 32'(busy), 1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("zero_idle", 32'(busy), 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("zero_pulses", fd_cnt - fd0, 1);
      checkOutput("zero_no_ss", ss_cnt - ss0, 0);

      // Last block of the frame coincides with a returned credit.
      $display("[TB] scenario: coincident issue and return");
      applyStimulus(1, 0, 16'd2, 0, 0);
      for (int c = 0; c < 6; c++) applyStimulus(0, 0, 0, 1, c == 5);
      checkOutput("coin_done_cnt", 32'(mcu_done_cnt), 1);
      checkOutput("coin_ready", 32'(blk_ready), 0);
      fd0 = fd_cnt;
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("coin_no_err", 32'(err_unexpected), 0);
      checkOutput("coin_done_cnt2", 32'(mcu_done_cnt), 2);
      wait_frame_done(10, fd0);

      // Stray credit while idle, then reset in the middle of a frame.
      $display("[TB] scenario: stray credit and reset");
      applyStimulus(0, 0, 0, 0, 1);
      for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("err_sticky", 32'(err_unexpected), 1);
      applyStimulus(1, 1, 16'd3, 0, 0);
      checkOutput("err_cleared", 32'(err_unexpected), 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      rst = 1'b0;
      #1;
      checkOutput("rst_ss_valid", 32'(ss_valid), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_ready", 32'(blk_ready), 0);
      ss0 = ss_cnt;
      for (int c = 0; c < 4; c++) applyStimulus(0, 0, 0, 1, 0);
      checkOutput("rst_no_ss", ss_cnt - ss0, 0);
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);

`ifdef MCU_SEQ_TIMEOUT_EN
      begin
         int n;
         $display("[TB] scenario: watchdog");
         check_en = 1'b0;
         fd0 = fd_cnt;
         applyStimulus(1, 0, 16'd2, 0, 0);
         for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 1, 0);
         blk_valid = 1'b0;
         n = 0;
         while (err_timeout !== 1'b1 && n < 40) begin
            applyStimulus(0, 0, 0, 0, 0);
            n++;
         end
         checkOutput("wd_err", 32'(err_timeout), 1);
         checkOutput("wd_window", 32'((n >= 15) && (n <= 19)), 1);
         checkOutput("wd_idle", 32'(busy), 0);
         applyStimulus(0, 0, 0, 0, 0);
         checkOutput("wd_no_frame_done", fd_cnt - fd0, 0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
